// File: rtl/sec10_countdown.sv
// 1 Hz down-counter from a switch preset (0-9 s) to zero, with one active-low 7-seg digit and a done flag.
// Optional DONE_BLINK_EN: blink the "0" digit at 1 Hz while in DONE.
module sec10_countdown #(
  parameter int FREQ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       clr_btn,
  input  logic [3:0] load_sw,
  output logic [3:0] sec,
  output logic       done,
  output logic [6:0] HEX
);

  localparam int PW = $clog2(FREQ);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t        state_reg;
  logic [PW-1:0] pre_reg;
  logic [3:0]    sec_reg;
  logic          done_reg;
  logic [6:0]    hex_reg;
  logic          start_s1, start_s2, start_s3;
  logic          clr_s1, clr_s2, clr_s3;
  logic          start_pulse, clr_pulse, tick;
  logic [3:0]    preset;

  assign start_pulse = start_s2 & ~start_s3;
  assign clr_pulse   = clr_s2 & ~clr_s3;
  assign tick        = (pre_reg == PW'(FREQ - 1));
  assign preset      = (load_sw > 4'd9) ? 4'd9 : load_sw;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      pre_reg   <= '0;
      sec_reg   <= 4'd0;
      done_reg  <= 1'b0;
      hex_reg   <= 7'b1000000;
      start_s1  <= 1'b0;
      start_s2  <= 1'b0;
      start_s3  <= 1'b0;
      clr_s1    <= 1'b0;
      clr_s2    <= 1'b0;
      clr_s3    <= 1'b0;
    end else begin
      start_s1 <= start_btn;
      start_s2 <= start_s1;
      start_s3 <= start_s2;
      clr_s1   <= clr_btn;
      clr_s2   <= clr_s1;
      clr_s3   <= clr_s2;

      // done and HEX deliberately lag the state/sec registers by one cycle
      done_reg <= (state_reg == DONE) && !clr_pulse;
`ifdef DONE_BLINK_EN
      if ((state_reg == DONE) && (pre_reg >= PW'(FREQ / 2)))
        hex_reg <= 7'b1111111;
      else
        hex_reg <= seg7(sec_reg);
`else
      hex_reg <= seg7(sec_reg);
`endif

      if (clr_pulse) begin
        state_reg <= IDLE;
        pre_reg   <= '0;
      end else begin
        case (state_reg)
          IDLE: begin
            sec_reg <= preset;
            pre_reg <= '0;
            if (start_pulse && (sec_reg != 4'd0))
              state_reg <= RUN;
          end
          RUN: begin
            if (tick) begin
              pre_reg <= '0;
              if (sec_reg == 4'd1) begin
                sec_reg   <= 4'd0;
                state_reg <= DONE;
              end else begin
                sec_reg <= sec_reg - 4'd1;
              end
            end else begin
              pre_reg <= pre_reg + PW'(1);
            end
            // reaching zero on the same cycle as a pause request takes priority
            if (start_pulse && !(tick && (sec_reg == 4'd1)))
              state_reg <= PAUSE;
          end
          PAUSE: begin
            if (start_pulse)
              state_reg <= RUN;
          end
          DONE: begin
            sec_reg <= 4'd0;
`ifdef DONE_BLINK_EN
            pre_reg <= tick ? '0 : pre_reg + PW'(1);
`else
            pre_reg <= '0;
`endif
            if (start_pulse)
              state_reg <= IDLE;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign sec  = sec_reg;
  assign done = done_reg;
  assign HEX  = hex_reg;

endmodule

// File: tb/tb_sec10_countdown.sv
// Self-checking bench for sec10_countdown (FREQ=10): directed table, corner sequences, random vs reference model.
module tb_sec10_countdown;

  localparam int FREQ = 10;
`ifdef DONE_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       start_btn;
  logic       clr_btn;
  logic [3:0] load_sw;
  logic [3:0] sec;
  logic       done;
  logic [6:0] hex_w;

  sec10_countdown #(.FREQ(FREQ)) dut (
    .clk(clk), .rst(rst), .start_btn(start_btn), .clr_btn(clr_btn),
    .load_sw(load_sw), .sec(sec), .done(done), .HEX(hex_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: mode 0=idle 1=counting 2=paused 3=finished
  int         m_mode, m_sec, m_phase;
  logic       m_done;
  logic [6:0] m_hex;
  logic [2:0] s_hist, c_hist;
  logic [6:0] digits [10];

  initial begin
    digits[0] = 7'b1000000; digits[1] = 7'b1111001; digits[2] = 7'b0100100;
    digits[3] = 7'b0110000; digits[4] = 7'b0011001; digits[5] = 7'b0010010;
    digits[6] = 7'b0000010; digits[7] = 7'b1111000; digits[8] = 7'b0000000;
    digits[9] = 7'b0010000;
  end

  task automatic model_step();
    logic sp, cp;
    int   preset;
    if (rst) begin
      m_mode = 0; m_sec = 0; m_phase = 0; m_done = 1'b0; m_hex = digits[0];
      s_hist = 3'b000; c_hist = 3'b000;
      return;
    end
    sp = s_hist[1] & ~s_hist[2];
    cp = c_hist[1] & ~c_hist[2];
    s_hist = {s_hist[1:0], start_btn};
    c_hist = {c_hist[1:0], clr_btn};
    preset = (int'(load_sw) > 9) ? 9 : int'(load_sw);
    m_hex  = (BLINK && m_mode == 3 && m_phase >= FREQ / 2) ? 7'b1111111 : digits[m_sec];
    m_done = !cp && (m_mode == 3);
    if (cp) begin
      m_mode = 0; m_phase = 0;
    end else begin
      case (m_mode)
        0: begin
          if (sp && m_sec != 0) m_mode = 1;
          m_sec = preset; m_phase = 0;
        end
        1: begin
          if (m_phase == FREQ - 1) begin
            m_sec = m_sec - 1;
            if (m_sec == 0) m_mode = 3;
          end
          m_phase = (m_phase + 1) % FREQ;
          if (sp && m_mode == 1) m_mode = 2;
        end
        2: if (sp) m_mode = 1;
        default: begin
          m_sec = 0;
          m_phase = BLINK ? (m_phase + 1) % FREQ : 0;
          if (sp) m_mode = 0;
        end
      endcase
    end
  endtask

  task automatic check_model(input string name);
    n_vec++;
    if (sec !== 4'(m_sec) || done !== m_done || hex_w !== m_hex) begin
      n_bad++;
      $display("FAIL %s: got sec=%0d done=%0b HEX=%b expected sec=%0d done=%0b HEX=%b",
               name, sec, done, hex_w, m_sec, m_done, m_hex);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("check %s: %0d ok", name, act);
    end
  endtask

  task automatic cyc(input logic r, input logic s, input logic c, input logic [3:0] l, input string name);
    rst = r; start_btn = s; clr_btn = c; load_sw = l;
    @(posedge clk);
    model_step();
    #1;
    check_model(name);
  endtask

  typedef struct {
    logic       r, s, c;
    logic [3:0] l;
    logic [3:0] e_sec;
    logic       e_done;
    logic [6:0] e_hex;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int t, n, first_done, blanks;
    int chg [$];
    bit held;
    logic [3:0] last;

    tbl[0]  = '{1'b1, 1'b0, 1'b0, 4'd5,  4'd0, 1'b0, 7'b1000000};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 4'd5,  4'd5, 1'b0, 7'b1000000};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 4'd5,  4'd5, 1'b0, 7'b0010010};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 4'd12, 4'd9, 1'b0, 7'b0010010};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 4'd12, 4'd9, 1'b0, 7'b0010000};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 4'd0,  4'd0, 1'b0, 7'b0010000};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 4'd0,  4'd0, 1'b0, 7'b1000000};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 4'd0,  4'd0, 1'b0, 7'b1000000};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 4'd0,  4'd0, 1'b0, 7'b1000000};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 4'd0,  4'd0, 1'b0, 7'b1000000};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 4'd7,  4'd7, 1'b0, 7'b1000000};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 4'd7,  4'd7, 1'b0, 7'b1111000};

    rst = 1'b1; start_btn = 1'b0; clr_btn = 1'b0; load_sw = 4'd0;

    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].r, tbl[i].s, tbl[i].c, tbl[i].l, "table_model");
      n_vec++;
      if (sec !== tbl[i].e_sec || done !== tbl[i].e_done || hex_w !== tbl[i].e_hex) begin
        n_bad++;
        $display("FAIL table[%0d]: got sec=%0d done=%0b HEX=%b expected sec=%0d done=%0b HEX=%b",
                 i, sec, done, hex_w, tbl[i].e_sec, tbl[i].e_done, tbl[i].e_hex);
      end else begin
        $display("vec %0d: sec=%0d done=%0b HEX=%b ok", i, sec, done, hex_w);
      end
    end

    // Full countdown from 3 with done timing and blink count
    cyc(0, 0, 0, 4'd3, "cd_load");
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 4'd3, "cd_start");
    t = 0; first_done = -1; last = sec;
    for (int i = 0; i < 40 && first_done < 0; i++) begin
      cyc(0, 0, 0, 4'd3, "cd_run");
      t++;
      if (sec != last) begin chg.push_back(t); last = sec; end
      if (done && first_done < 0) first_done = t;
    end
    chk("cd_changes", chg.size(), 3);
    chk("cd_step1", (chg.size() > 0) ? chg[0] : -1, 10);
    chk("cd_step2", (chg.size() > 1) ? chg[1] : -1, 20);
    chk("cd_step3", (chg.size() > 2) ? chg[2] : -1, 30);
    chk("cd_done_cycle", first_done, 31);
    blanks = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 0, 4'd3, "done_hold");
      if (hex_w == 7'b1111111) blanks++;
    end
    chk("done_blank_cycles", blanks, BLINK ? 5 : 0);
    chk("done_sec_zero", int'(sec), 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 4'd3, "done_start");
    cyc(0, 0, 0, 4'd3, "done_reload");
    chk("reload_sec", int'(sec), 3);
    chk("reload_done", int'(done), 0);

    // Pause at sec=7, pre=4, then resume from the held prescaler
    cyc(0, 0, 0, 4'd8, "pz_load");
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 4'd8, "pz_start");
    for (int i = 0; i < 15 && sec != 4'd7; i++) cyc(0, 0, 0, 4'd8, "pz_wait7");
    chk("pz_reached7", int'(sec), 7);
    cyc(0, 0, 0, 4'd8, "pz_pre1");
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 4'd8, "pz_pause");
    held = 1'b1;
    for (int i = 0; i < 50; i++) begin
      cyc(0, 0, 0, 4'd8, "pz_hold");
      if (sec != 4'd7) held = 1'b0;
    end
    chk("pz_held", int'(held), 1);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 4'd8, "pz_resume");
    n = 0;
    for (int i = 0; i < 20 && sec == 4'd7; i++) begin
      cyc(0, 0, 0, 4'd8, "pz_after");
      n++;
    end
    chk("pz_resume_gap", n, 6);

    // clr and start together while counting
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 4'd8, "clr_start");
    cyc(0, 0, 0, 4'd8, "clr_idle");
    chk("clr_sec_preset", int'(sec), 8);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 4'd8, "clr_stay");
    chk("clr_stays_idle", int'(sec), 8);

    // rst in the middle of a run
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 4'd6, "rst_start");
    for (int i = 0; i < 14; i++) cyc(0, 0, 0, 4'd6, "rst_run");
    cyc(1, 0, 0, 4'd6, "rst_mid");
    chk("rst_sec", int'(sec), 0);
    chk("rst_hex", int'(hex_w), int'(7'b1000000));
    chk("rst_done", int'(done), 0);

    // Randomized buttons, presets, clears and resets
    begin
      logic s, c, r;
      logic [3:0] l;
      s = 1'b0; c = 1'b0; l = 4'd4;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 9) == 0) s = ~s;
        if ($urandom_range(0, 59) == 0) c = ~c;
        if ($urandom_range(0, 29) == 0) l = 4'($urandom_range(0, 15));
        r = ($urandom_range(0, 799) == 0);
        cyc(r, s, c, l, "random");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
